binary_map_writer: RTL and testbench
====================================

// Module: binary_map_writer
// PURPOSE
//  Producer side of the binary_map_buffer SRAM-style port. Accepts a 1-bit-per-cycle
//  valid/ready pixel stream, packs 16 pixels per word LSB-first, and issues single-cycle
//  write strobes (CEN/WEN/A/D) into a ping-pong pair of frame banks (bank = A[width]).
//  Sits between the binarization stage and the map buffer; signals each completed frame.
// PARAMETERS
//  dimen  1024  frame edge in pixels; words per frame NUM = dimen*dimen/16
//  width  16    address MSB index; A[width-1:0] = word address, A[width] = bank select
// PORTS
//  CLK        in   1        single clock, all logic on posedge
//  RESET      in   1        synchronous, active-high
//  en         in   1        writer enable; 0 -> pix_ready=0, no new pixels accepted
//  pix_valid  in   1        pixel valid
//  pix_ready  out  1        pixel accepted when pix_valid & pix_ready
//  pix_data   in   1        binary pixel
//  pix_last   in   1        last pixel of frame (qualified by accept)
//  CEN        out  1        buffer chip enable, active-low
//  WEN        out  1        buffer write enable, active-low
//  A          out  width+1  buffer address {bank, word_addr}
//  D          out  16       buffer write data
//  RETN       out  1        buffer retention enable; 0 in reset, 1 otherwise
//  Q          in   16       buffer read data (valid 1 cycle after read strobe)
//  bank       out  1        bank currently being filled
//  frame_done out  1        1-cycle pulse, coincident with a frame's final write strobe
//  err        out  1        sticky readback mismatch (verify build only)
// BEHAVIOUR
//  - Reset (RESET=1 at posedge): CEN=1, WEN=1, A=0, D=0, RETN=0, pix_ready=0, bank=0,
//    frame_done=0, err=0; bit count, word_addr, pack reg, hold reg cleared. Reset
//    mid-word discards the partial word; no strobe is issued.
//  - pix_ready = en & ~RESET & ~hold_full (& ~verify_busy when VERIFY_EN).
//  - Packing: k-th accepted pixel of a word goes to pack[k], k=0..15.
//  - Word complete: 16th pixel, or pix_last on any pixel. With pix_last, unfilled bits
//    are 0. Complete word moves to hold reg; pack reg and bit count clear same cycle.
//  - Write strobe: cycle after completion (accept at t -> strobe at t+1): CEN=0, WEN=0,
//    A={bank,word_addr}, D=hold. Exactly one strobe cycle per word; CEN=WEN=1 otherwise
//    except verify reads. Outputs registered; D and A hold after strobe until next op.
//  - After strobe, word_addr increments. Frame end = word with pix_last, or word at
//    word_addr=NUM-1: frame_done=1 on that strobe, word_addr wraps to 0, bank toggles.
//    pix_last on word NUM-1 is a single frame end (no double toggle).
//  - Simultaneous pixel accept and strobe of previous word allowed: throughput 1 px/clk.
//  - en deasserted mid-word: pack state held; packing resumes when en returns.
//  - FSM: IDLE (hold empty) -> WRITE (strobe) -> IDLE, or -> VRD -> VCMP -> IDLE (verify).
// CONFIGURATION
//  BINARY_MAP_WRITER_VERIFY_EN defined: each write strobe at t is followed by a read
//  strobe at t+1 (CEN=0, WEN=1, same A); Q sampled at t+2 and compared with written D;
//  mismatch sets err (sticky until RESET). pix_ready=0 from strobe through compare
//  cycle. Not defined: no read strobes, Q ignored, err tied 0, pix_ready never
//  stalled by verify.
// TESTING
//  1. RESET, en=1, 16 px 1,0,1,0.. -> one strobe A=17'h00000, D=16'h5555, CEN=WEN=0.
//  2. 32 px all 1, last on px32 -> strobes A=0,1, D=16'hFFFF; frame_done on 2nd strobe;
//     next frame's first word at A=17'h10000, bank=1.
//  3. 5 px of 1 with last on 5th -> D=16'h001F, frame_done=1, word_addr back to 0.
//  4. 10 px then RESET for 1 cycle, then 16 px of 0 -> single strobe A=0, D=16'h0000.
//  5. VERIFY_EN, bench returns Q=16'h0000 after writing 16'h5555 -> err=1, stays 1;
//     matching Q -> err=0; read strobe seen at t+1 with WEN=1.
//  6. Toggle en=0 for 3 cycles mid-word -> pix_ready=0, no strobe; resume -> word correct.

Source files
------------

// File: rtl/binary_map_writer.sv
// Packs a 1-bit pixel stream LSB-first into 16-bit words and writes them into a ping-pong
// pair of SRAM frame banks. Define BINARY_MAP_WRITER_VERIFY_EN for write-then-readback checking.
module binary_map_writer #(
    parameter int dimen = 1024,
    parameter int width = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_data,
    input  logic             pix_last,
    output logic             CEN,
    output logic             WEN,
    output logic [width:0]   A,
    output logic [15:0]      D,
    output logic             RETN,
    input  logic [15:0]      Q,
    output logic             bank,
    output logic             frame_done,
    output logic             err,
    output logic [1:0]       dbg_state_o
);
    localparam int NUM = dimen * dimen / 16;
    localparam logic [width-1:0] LAST_ADDR = width'(NUM - 1);

    typedef enum logic [1:0] {IDLE, WRITE, VRD, VCMP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       pack_q, pack_d;
    logic              last_q, last_d;
    logic [width-1:0]  addr_q, addr_d;
    logic              bank_q, bank_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [width:0]    a_q, a_d;
    logic [15:0]       d_q, d_d;
    logic              retn_q;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic              busy;
    logic              accept;
    logic              complete;
    logic              frame_end;
    logic [15:0]       word;
    logic [width-1:0]  addr_nxt;
    logic              bank_nxt;

    // Handshake: a pixel transfers on a posedge where pix_valid & pix_ready are both high;
    // pix_ready never depends on pix_valid.
`ifdef BINARY_MAP_WRITER_VERIFY_EN
    assign busy = (state_q != IDLE);
`else
    assign busy = 1'b0;
    logic unused_q;
    assign unused_q = ^Q;
`endif

    assign pix_ready = en & ~RESET & ~busy;
    assign accept    = pix_valid & pix_ready;
    assign word      = pack_q | ({15'b0, pix_data} << cnt_q);
    assign complete  = accept & ((cnt_q == 4'hF) | pix_last);

    // Address/bank as they will be once the strobe in flight retires, so a word completing
    // during a strobe cycle lands at the following address.
    always_comb begin
        addr_nxt = addr_q;
        bank_nxt = bank_q;
        if (state_q == WRITE) begin
            if (last_q) begin
                addr_nxt = '0;
                bank_nxt = ~bank_q;
            end else begin
                addr_nxt = addr_q + width'(1);
            end
        end
    end

    assign frame_end = pix_last | (addr_nxt == LAST_ADDR);

    // D register doubles as the hold register: it keeps the written word for readback.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        last_d       = last_q;
        addr_d       = addr_nxt;
        bank_d       = bank_nxt;
        cen_d        = 1'b1;
        wen_d        = 1'b1;
        a_d          = a_q;
        d_d          = d_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        if (accept) begin
            if (complete) begin
                pack_d       = '0;
                cnt_d        = '0;
                last_d       = frame_end;
                cen_d        = 1'b0;
                wen_d        = 1'b0;
                a_d          = {bank_nxt, addr_nxt};
                d_d          = word;
                frame_done_d = frame_end;
            end else begin
                pack_d = word;
                cnt_d  = cnt_q + 4'd1;
            end
        end
`ifdef BINARY_MAP_WRITER_VERIFY_EN
        case (state_q)
            IDLE:  if (complete) state_d = WRITE;
            WRITE: begin
                state_d = VRD;
                cen_d   = 1'b0;
                wen_d   = 1'b1;
            end
            VRD:   state_d = VCMP;
            VCMP: begin
                state_d = IDLE;
                if (Q != d_q) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
`else
        state_d = complete ? WRITE : IDLE;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pack_q       <= '0;
            last_q       <= 1'b0;
            addr_q       <= '0;
            bank_q       <= 1'b0;
            cen_q        <= 1'b1;
            wen_q        <= 1'b1;
            a_q          <= '0;
            d_q          <= '0;
            retn_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            bank_q       <= bank_d;
            cen_q        <= cen_d;
            wen_q        <= wen_d;
            a_q          <= a_d;
            d_q          <= d_d;
            retn_q       <= 1'b1;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign CEN         = cen_q;
    assign WEN         = wen_q;
    assign A           = a_q;
    assign D           = d_q;
    assign RETN        = retn_q;
    assign bank        = bank_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_binary_map_writer.sv
// Bench for binary_map_writer: word-level model checked every cycle plus directed
// literal expectations. Small frame (dimen=16 -> 16 words) so the wrap boundary is reachable.
module tb_binary_map_writer;
    localparam int NUM = 16;

    logic        CLK;
    logic        RESET;
    logic        en;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic        pix_last;
    logic        CEN;
    logic        WEN;
    logic [16:0] A;
    logic [15:0] D;
    logic        RETN;
    logic [15:0] Q;
    logic        bank;
    logic        frame_done;
    logic        err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    binary_map_writer #(.dimen(16), .width(16)) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .CEN(CEN), .WEN(WEN), .A(A), .D(D),
        .RETN(RETN), .Q(Q), .bank(bank), .frame_done(frame_done), .err(err),
        .dbg_state_o(dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Simple memory stand-in: reads return the last written word, or zero when corrupting.
    bit          q_corrupt = 1'b0;
    logic [15:0] last_wr = 16'h0;
    initial Q = 16'h0;
    always @(posedge CLK) begin
        if (!CEN && !WEN) last_wr <= D;
        if (!CEN && WEN)  Q <= q_corrupt ? 16'h0000 : last_wr;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collects accepted bits into a word, assigns word addresses and
    // banks frame by frame, and predicts the outputs for the cycle after each edge.
    bit          started = 1'b0;
    logic [15:0] acc;
    int          nbits;
    int          waddr;
    bit          mbank;
    int          vstep = 0;
    logic        exp_cen, exp_wen, exp_fd, exp_bank, exp_retn, exp_err;
    logic [16:0] exp_a;
    logic [15:0] exp_d;
    bit          acc_ok;

    always @(posedge CLK) begin
        started = 1'b1;
        if (RESET) begin
            acc = '0; nbits = 0; waddr = 0; mbank = 1'b0; vstep = 0;
            exp_cen = 1'b1; exp_wen = 1'b1; exp_a = '0; exp_d = '0; exp_retn = 1'b0;
            exp_fd = 1'b0; exp_bank = 1'b0; exp_err = 1'b0;
        end else begin
            acc_ok = pix_valid && en && (vstep == 0);
            exp_retn = 1'b1; exp_cen = 1'b1; exp_wen = 1'b1; exp_fd = 1'b0;
            exp_bank = mbank;
            if (vstep > 0) begin
                if (vstep == 3) begin exp_cen = 1'b0; exp_wen = 1'b1; end
                if (vstep == 1 && Q !== exp_d) exp_err = 1'b1;
                vstep--;
            end
            if (acc_ok) begin
                acc[nbits] = pix_data;
                nbits++;
                if (nbits == 16 || pix_last) begin
                    exp_cen = 1'b0; exp_wen = 1'b0;
                    exp_a   = {mbank, 16'(waddr)};
                    exp_d   = acc;
                    exp_fd  = pix_last || (waddr == NUM - 1);
                    if (exp_fd) begin waddr = 0; mbank = !mbank; end
                    else waddr++;
                    acc = '0; nbits = 0;
`ifdef BINARY_MAP_WRITER_VERIFY_EN
                    vstep = 3;
`endif
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("pix_ready", 48'(pix_ready), 48'(en && !RESET && (vstep == 0)));
            chk("ctl_outs", 48'({CEN, WEN, frame_done, bank, RETN, err}),
                48'({exp_cen, exp_wen, exp_fd, exp_bank, exp_retn, exp_err}));
            chk("addr", 48'(A), 48'(exp_a));
            chk("data", 48'(D), 48'(exp_d));
        end
    end

    logic [33:0] dut_wr[$];
    logic [16:0] dut_rd[$];
    always @(negedge CLK) begin
        if (started && !RESET) begin
            if (!CEN && !WEN) dut_wr.push_back({frame_done, A, D});
            if (!CEN && WEN)  dut_rd.push_back(A);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; pix_valid = 1'b0; pix_last = 1'b0; pix_data = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ctl", 48'({CEN, WEN, RETN, pix_ready, bank, frame_done, err}), 48'(7'b1100000));
        chk("rst_ad", 48'({A, D}), 48'(0));
        RESET = 1'b0;
    endtask

    task automatic send_px(input logic b, input logic l);
        bit rdy;
        int tries;
        pix_valid = 1'b1; pix_data = b; pix_last = l; tries = 0;
        do begin
            @(negedge CLK);
            rdy = pix_ready;
            @(posedge CLK);
            #1;
            tries++;
        end while (!rdy && tries < 100);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got no pix_ready required accept within 100 cycles");
        end
        pix_valid = 1'b0; pix_last = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input bit last);
        for (int k = 0; k < n; k++) send_px(v[k], last && (k == n - 1));
    endtask

    task automatic expect_wr(input string name, input logic [16:0] a, input logic [15:0] d,
                             input logic fd);
        logic [33:0] e;
        if (dut_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got no write strobe required A=%h D=%h fd=%0d", name, a, d, fd);
        end else begin
            e = dut_wr.pop_front();
            chk(name, 48'(e), 48'({fd, a, d}));
        end
    endtask

    initial begin
        RESET = 1'b1; en = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; pix_last = 1'b0;

        // alternating pixels starting with 1 -> 0x5555 at word 0
        do_reset(); dut_wr.delete();
        for (int k = 0; k < 16; k++) send_px(k % 2 == 0, 1'b0);
        idle(3);
        expect_wr("t1_word", 17'h00000, 16'h5555, 1'b0);

        // two-word frame ending on pixel 32, then first word of bank 1
        do_reset(); dut_wr.delete();
        for (int k = 0; k < 32; k++) send_px(1'b1, k == 31);
        idle(3);
        expect_wr("t2_w0", 17'h00000, 16'hFFFF, 1'b0);
        expect_wr("t2_w1", 17'h00001, 16'hFFFF, 1'b1);
        chk("t2_bank", 48'(bank), 48'(1));
        send_bits(16'h00F0, 16, 1'b0);
        idle(3);
        expect_wr("t2_bank1", 17'h10000, 16'h00F0, 1'b0);

        // short frame, then a one-pixel frame back-to-back
        do_reset(); dut_wr.delete();
        send_bits(16'h001F, 5, 1'b1);
        send_bits(16'h0001, 1, 1'b1);
        idle(3);
        expect_wr("t3_short", 17'h00000, 16'h001F, 1'b1);
        expect_wr("t3_single", 17'h10000, 16'h0001, 1'b1);
        chk("t3_bank", 48'(bank), 48'(0));

        // reset mid-word discards the partial word
        do_reset(); dut_wr.delete();
        send_bits(16'h03FF, 10, 1'b0);
        do_reset();
        send_bits(16'h0000, 16, 1'b0);
        idle(3);
        chk("t4_count", 48'(dut_wr.size()), 48'(1));
        expect_wr("t4_word", 17'h00000, 16'h0000, 1'b0);

        // en dropped for 3 cycles mid-word
        do_reset(); dut_wr.delete();
        send_bits(16'hA3C5, 8, 1'b0);
        pix_valid = 1'b1; pix_data = 1'b1; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t6_ready_low", 48'(pix_ready), 48'(0));
            @(posedge CLK);
            #1;
        end
        chk("t6_no_strobe", 48'(dut_wr.size()), 48'(0));
        en = 1'b1;
        for (int k = 8; k < 16; k++) send_px((16'hA3C5 >> k) & 16'h1, 1'b0);
        idle(3);
        expect_wr("t6_word", 17'h00000, 16'hA3C5, 1'b0);

        // frame wraps at word NUM-1 without pix_last
        do_reset();
        for (int w = 0; w < NUM - 1; w++) send_bits(16'(w) * 16'h0101, 16, 1'b0);
        idle(2); dut_wr.delete();
        send_bits(16'hBEEF, 16, 1'b0);
        send_bits(16'h0F0F, 16, 1'b0);
        idle(3);
        expect_wr("t7_last", 17'h0000F, 16'hBEEF, 1'b1);
        expect_wr("t7_wrap", 17'h10000, 16'h0F0F, 1'b0);

        // pix_last on word NUM-1 is a single frame end
        do_reset();
        for (int w = 0; w < NUM - 1; w++) send_bits(16'hFFFF ^ 16'(w), 16, 1'b0);
        idle(2); dut_wr.delete();
        send_bits(16'h1234, 16, 1'b1);
        idle(3);
        expect_wr("t8_last", 17'h0000F, 16'h1234, 1'b1);
        chk("t8_bank", 48'(bank), 48'(1));
        send_bits(16'h4321, 16, 1'b0);
        idle(3);
        expect_wr("t8_next", 17'h10000, 16'h4321, 1'b0);

`ifdef BINARY_MAP_WRITER_VERIFY_EN
        // readback mismatch sets sticky err; clean readback after reset keeps it clear
        do_reset(); dut_wr.delete(); dut_rd.delete(); q_corrupt = 1'b1;
        send_bits(16'h5555, 16, 1'b0);
        idle(6);
        chk("t5_err_set", 48'(err), 48'(1));
        chk("t5_rd_count", 48'(dut_rd.size()), 48'(1));
        if (dut_rd.size() > 0) chk("t5_rd_addr", 48'(dut_rd[0]), 48'(0));
        q_corrupt = 1'b0;
        send_bits(16'h1234, 16, 1'b0);
        idle(6);
        chk("t5_err_sticky", 48'(err), 48'(1));
        do_reset();
        send_bits(16'h5555, 16, 1'b0);
        idle(6);
        chk("t5_err_clear", 48'(err), 48'(0));
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
